// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bus bundling the decode handshake and the instruction memory port.
interface fetch_unit_if #(parameter int ADDR_W = 9);
  logic              stall_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_rdata_i;
  logic              valid_o;
  logic [31:0]       instr_o;
  logic [31:0]       pc_o;
  logic [31:0]       pc_plus4_o;
  logic [31:0]       fetch_count_o;
  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    output imem_addr_o, valid_o, instr_o, pc_o, pc_plus4_o, fetch_count_o
  );
  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    input  imem_addr_o, valid_o, instr_o, pc_o, pc_plus4_o, fetch_count_o
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner for a 1-cycle-latency instruction memory, with stall hold buffer and redirect squash.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 9,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  logic [31:0] r_f_pc, r_d_pc, r_hold_instr, r_fetch_count;
  logic        r_d_valid;
  logic [0:0]  r_state;
  logic        w_accept;
  logic [31:0] w_redirect_pc;
  assign w_accept       = r_d_valid && !bus.stall_i && !bus.redirect_i;
  assign w_redirect_pc  = bus.redirect_pc_i & ~32'd3;
  assign bus.imem_addr_o   = r_f_pc[ADDR_W+1:2];
  assign bus.valid_o       = r_d_valid;
  assign bus.pc_o          = r_d_pc;
  assign bus.pc_plus4_o    = r_d_pc + 32'd4;
  assign bus.fetch_count_o = r_fetch_count;
  assign bus.instr_o = !r_d_valid ? NOP_INSTR : (r_state == HOLD) ? r_hold_instr : bus.imem_rdata_i;
  // The memory word for d_pc is only on imem_rdata_i for one cycle, so a stall captures it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_pc        <= RESET_PC;
      r_d_pc        <= RESET_PC;
      r_d_valid     <= 1'b0;
      r_hold_instr  <= 32'd0;
      r_state       <= FETCH;
      r_fetch_count <= 32'd0;
    end else begin
      r_fetch_count <= r_fetch_count + 32'(w_accept);
      if (bus.redirect_i) begin
        r_f_pc    <= w_redirect_pc;
        r_d_valid <= 1'b0;
        r_state   <= FETCH;
      end else if (bus.stall_i) begin
        if (r_state == FETCH) begin
          r_hold_instr <= bus.imem_rdata_i;
          r_state      <= HOLD;
        end
      end else begin
        r_f_pc    <= r_f_pc + 32'd4;
        r_d_pc    <= r_f_pc;
        r_d_valid <= 1'b1;
        r_state   <= FETCH;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; the driver predicts the in-order stream of accepted PCs, the monitor checks it.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  logic [31:0] q[$];
  logic [31:0] nxt = 32'd0;
  logic [31:0] mcount = 32'd0;
  fetch_unit_if #(.ADDR_W(9)) bus ();
  fetch_unit #(.RESET_PC(32'h0), .ADDR_W(9), .NOP_INSTR(NOP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  // Memory contents are mem[i] = 0x1000_0000 + i, 512 words.
  always @(posedge clk) bus.imem_rdata_i <= 32'h1000_0000 + 32'(bus.imem_addr_o);
  function automatic logic [31:0] mem_at(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) % 512);
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic s, input logic r, input logic [31:0] t);
    bus.stall_i = s;
    bus.redirect_i = r;
    bus.redirect_pc_i = t;
    if (r) begin
      q.delete();
      nxt = t & ~32'd3;
    end
    while (q.size() < 4) begin
      q.push_back(nxt);
      nxt += 32'd4;
    end
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst_n) mcount = 32'd0;
    else begin
      check("fetch_count", bus.fetch_count_o, mcount);
      if (!bus.valid_o) check("nop_when_invalid", bus.instr_o, NOP);
      else if (!bus.redirect_i) begin
        if (q.size() == 0) check("queue_empty", 32'd0, 32'd1);
        else begin
          check("pc", bus.pc_o, q[0]);
          check("instr", bus.instr_o, mem_at(q[0]));
          check("pc_plus4", bus.pc_plus4_o, q[0] + 32'd4);
          if (!bus.stall_i) begin
            void'(q.pop_front());
            mcount++;
            n_acc++;
          end
        end
      end
    end
  end
  initial begin
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_pc", bus.pc_o, 32'd0);
    check("rst_pc4", bus.pc_plus4_o, 32'd4);
    rst_n = 1'b1;
    check("first_cycle_nop", bus.instr_o, NOP);
    repeat (3) cyc(1'b0, 1'b0, 32'd0);
    check("pc_8", bus.pc_o, 32'd8);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'd0);
      check("stall_pc", bus.pc_o, 32'd8);
      check("stall_instr", bus.instr_o, 32'h1000_0002);
      check("stall_count", bus.fetch_count_o, 32'd2);
    end
    cyc(1'b0, 1'b0, 32'd0);
    check("after_stall_pc", bus.pc_o, 32'd12);
    check("after_stall_instr", bus.instr_o, 32'h1000_0003);
    cyc(1'b0, 1'b0, 32'd0);
    check("pc_10", bus.pc_o, 32'h10);
    cyc(1'b0, 1'b1, 32'h104);
    check("redir_bubble", 32'(bus.valid_o), 32'd0);
    check("redir_no_count", bus.fetch_count_o, 32'd4);
    cyc(1'b0, 1'b0, 32'd0);
    check("redir_pc", bus.pc_o, 32'h104);
    check("redir_instr", bus.instr_o, 32'h1000_0041);
    check("redir_pc4", bus.pc_plus4_o, 32'h108);
    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 32'h7FC);
    check("hold_redir_bubble", 32'(bus.valid_o), 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    check("pc_7fc", bus.pc_o, 32'h7FC);
    check("instr_7fc", bus.instr_o, 32'h1000_01FF);
    check("addr_wrap", 32'(bus.imem_addr_o), 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    check("pc_800", bus.pc_o, 32'h800);
    check("instr_800", bus.instr_o, 32'h1000_0000);
    cyc(1'b0, 1'b1, 32'h23);
    cyc(1'b0, 1'b0, 32'd0);
    check("misalign_pc", bus.pc_o, 32'h20);
    check("misalign_instr", bus.instr_o, 32'h1000_0008);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) == 0), $urandom);
    repeat (3) cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.valid_o), 32'd0);
    check("async_rst_pc", bus.pc_o, 32'd0);
    check("async_rst_count", bus.fetch_count_o, 32'd0);
    check("async_rst_instr", bus.instr_o, NOP);
    q.delete();
    nxt = 32'd0;
    @(posedge clk);
    #1;
    bus.stall_i = 1'b0;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 32'd0);
    check("restart_pc", bus.pc_o, 32'd0);
    check("restart_instr", bus.instr_o, 32'h1000_0000);
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0), $urandom);
    check("progress", 32'(n_acc > 250), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
